// File: rtl/dmac_write_response_tracker.sv
// dmac_write_response_tracker
//   Tracks write bursts issued on AW, consumes the AXI B channel in issue order
//   (single AXI ID) and accumulates bytes and response status per DMA channel.
//   When the last burst of a channel's transfer is acknowledged, one
//   completion record is presented on the done_* interface.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   issue_*             burst issue entry {channel, bytes, last}, valid/ready
//   m_axi_b*            AXI write response channel
//   done_*              completion record, valid/ready
//   outstanding_count   in-flight burst FIFO occupancy
//   busy                bursts in flight or a completion record pending
module dmac_write_response_tracker #(
  parameter int ADDR_WD         = 32,
  parameter int CHANNEL_COUNT   = 8,
  parameter int MAX_OUTSTANDING = 4,
  localparam int CH_WD  = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1,
  localparam int CNT_WD = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               issue_valid,
  output logic               issue_ready,
  input  logic [CH_WD-1:0]   issue_channel,
  input  logic [ADDR_WD-1:0] issue_bytes,
  input  logic               issue_last,
  input  logic               m_axi_bvalid,
  output logic               m_axi_bready,
  input  logic [1:0]         m_axi_bresp,
  output logic               done_valid,
  input  logic               done_ready,
  output logic [CH_WD-1:0]   done_channel,
  output logic [ADDR_WD-1:0] done_bytes,
  output logic               done_error,
  output logic [1:0]         done_resp,
  output logic [CNT_WD-1:0]  outstanding_count,
  output logic               busy
);

  localparam int PTR_WD = $clog2(MAX_OUTSTANDING);
  localparam logic [CNT_WD-1:0] FULL_CNT = CNT_WD'(MAX_OUTSTANDING);
  localparam logic [CNT_WD-1:0] CNT_ONE  = CNT_WD'(1);
  localparam logic [PTR_WD-1:0] PTR_ONE  = PTR_WD'(1);

  // In-flight burst FIFO
  logic [CH_WD-1:0]   fifo_ch_q    [MAX_OUTSTANDING];
  logic [ADDR_WD-1:0] fifo_bytes_q [MAX_OUTSTANDING];
  logic               fifo_last_q  [MAX_OUTSTANDING];
  logic [PTR_WD-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_WD-1:0]  count_q, count_d;

  // Per-channel accumulators
  logic [ADDR_WD-1:0] acc_q   [CHANNEL_COUNT];
  logic               err_q   [CHANNEL_COUNT];
  logic [1:0]         worst_q [CHANNEL_COUNT];

  // Completion record
  logic               done_valid_q;
  logic [CH_WD-1:0]   done_channel_q;
  logic [ADDR_WD-1:0] done_bytes_q;
  logic               done_error_q;
  logic [1:0]         done_resp_q;

  logic               empty, full, push, pop;
  logic [CH_WD-1:0]   head_ch;
  logic [ADDR_WD-1:0] head_bytes;
  logic               head_last;
  logic [ADDR_WD-1:0] merged_bytes;
  logic               merged_err;
  logic [1:0]         merged_worst;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  // issue_ready looks only at registered occupancy, never at a same-cycle pop.
  assign issue_ready = !full;
  // Every pop may produce a record, so all pops stall while one is pending.
  assign m_axi_bready = !empty && (!done_valid_q || done_ready);

  assign push = issue_valid && issue_ready;
  assign pop  = m_axi_bvalid && m_axi_bready;

  assign head_ch    = fifo_ch_q[rd_ptr_q];
  assign head_bytes = fifo_bytes_q[rd_ptr_q];
  assign head_last  = fifo_last_q[rd_ptr_q];

  // bresp[1] marks SLVERR/DECERR; numeric max of those gives the worst one.
  always_comb begin
    merged_bytes = acc_q[head_ch] + head_bytes;
    merged_err   = err_q[head_ch] | m_axi_bresp[1];
    merged_worst = worst_q[head_ch];
    if (m_axi_bresp[1] && (m_axi_bresp > worst_q[head_ch])) begin
      merged_worst = m_axi_bresp;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage carries no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_ch_q[wr_ptr_q]    <= issue_channel;
      fifo_bytes_q[wr_ptr_q] <= issue_bytes;
      fifo_last_q[wr_ptr_q]  <= issue_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNEL_COUNT; i++) begin
        acc_q[i]   <= '0;
        err_q[i]   <= 1'b0;
        worst_q[i] <= 2'b00;
      end
    end else if (pop) begin
      if (head_last) begin
        acc_q[head_ch]   <= '0;
        err_q[head_ch]   <= 1'b0;
        worst_q[head_ch] <= 2'b00;
      end else begin
        acc_q[head_ch]   <= merged_bytes;
        err_q[head_ch]   <= merged_err;
        worst_q[head_ch] <= merged_worst;
      end
    end
  end

  // A last pop with a record being consumed reloads in the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_valid_q   <= 1'b0;
      done_channel_q <= '0;
      done_bytes_q   <= '0;
      done_error_q   <= 1'b0;
      done_resp_q    <= 2'b00;
    end else if (pop && head_last) begin
      done_valid_q   <= 1'b1;
      done_channel_q <= head_ch;
      done_bytes_q   <= merged_bytes;
      done_error_q   <= merged_err;
      done_resp_q    <= merged_worst;
    end else if (done_ready) begin
      done_valid_q   <= 1'b0;
    end
  end

  assign done_valid        = done_valid_q;
  assign done_channel      = done_channel_q;
  assign done_bytes        = done_bytes_q;
  assign done_error        = done_error_q;
  assign done_resp         = done_resp_q;
  assign outstanding_count = count_q;
  assign busy              = !empty || done_valid_q;

  a_no_issue_when_full: assert property (
    @(posedge clk) disable iff (!rst_n) issue_valid |-> issue_ready);

  a_no_pop_when_empty: assert property (
    @(posedge clk) disable iff (!rst_n) pop |-> !empty);

  a_done_stable: assert property (
    @(posedge clk) disable iff (!rst_n)
    (done_valid_q && !done_ready) |=>
      (done_valid_q && $stable(done_channel_q) && $stable(done_bytes_q) &&
       $stable(done_error_q) && $stable(done_resp_q)));

endmodule

// File: tb/tb_dmac_write_response_tracker.sv
module tb_dmac_write_response_tracker;

  localparam int ADDR_WD = 32;
  localparam int CH_CNT  = 8;
  localparam int MAX_OUT = 4;
  localparam int CH_WD   = 3;
  localparam int CNT_WD  = 3;

  logic               clk;
  logic               rst_n;
  logic               issue_valid;
  logic               issue_ready;
  logic [CH_WD-1:0]   issue_channel;
  logic [ADDR_WD-1:0] issue_bytes;
  logic               issue_last;
  logic               m_axi_bvalid;
  logic               m_axi_bready;
  logic [1:0]         m_axi_bresp;
  logic               done_valid;
  logic               done_ready;
  logic [CH_WD-1:0]   done_channel;
  logic [ADDR_WD-1:0] done_bytes;
  logic               done_error;
  logic [1:0]         done_resp;
  logic [CNT_WD-1:0]  outstanding_count;
  logic               busy;

  dmac_write_response_tracker #(
    .ADDR_WD(ADDR_WD), .CHANNEL_COUNT(CH_CNT), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_channel(issue_channel), .issue_bytes(issue_bytes), .issue_last(issue_last),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
    .done_valid(done_valid), .done_ready(done_ready), .done_channel(done_channel),
    .done_bytes(done_bytes), .done_error(done_error), .done_resp(done_resp),
    .outstanding_count(outstanding_count), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  typedef struct {
    int unsigned ch;
    logic [31:0] bytes;
    bit          last;
  } ent_t;

  typedef struct {
    int unsigned ch;
    logic [31:0] bytes;
    bit          err;
    logic [1:0]  resp;
  } rec_t;

  // Behavioural model: burst queue, per-channel totals, pending record
  ent_t        q[$];
  logic [31:0] m_acc   [CH_CNT];
  bit          m_err   [CH_CNT];
  logic [1:0]  m_worst [CH_CNT];
  bit          m_dv;
  rec_t        m_rec;
  rec_t        obs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    for (int i = 0; i < CH_CNT; i++) begin
      m_acc[i] = '0; m_err[i] = 1'b0; m_worst[i] = 2'b00;
    end
    m_dv = 1'b0;
    m_rec = '{ch: 0, bytes: '0, err: 1'b0, resp: 2'b00};
  endfunction

  function automatic rec_t obs_at(input int i);
    rec_t r;
    r = '{ch: 99, bytes: '1, err: 1'b1, resp: 2'b11};
    if (i < obs.size()) r = obs[i];
    return r;
  endfunction

  // Every cycle: DUT outputs against the model after the edge settled.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("issue_ready", 64'(issue_ready), 64'(q.size() < MAX_OUT));
      chk("bready", 64'(m_axi_bready), 64'((q.size() != 0) && (!m_dv || done_ready)));
      chk("outstanding_count", 64'(outstanding_count), 64'(q.size()));
      chk("busy", 64'(busy), 64'((q.size() != 0) || m_dv));
      chk("done_valid", 64'(done_valid), 64'(m_dv));
      if (m_dv) begin
        chk("done_channel", 64'(done_channel), 64'(m_rec.ch));
        chk("done_bytes", 64'(done_bytes), 64'(m_rec.bytes));
        chk("done_error", 64'(done_error), 64'(m_rec.err));
        chk("done_resp", 64'(done_resp), 64'(m_rec.resp));
      end
    end
  end

  // One clock cycle: drive inputs, advance the model across the edge.
  // Called at negedge+1; returns at the following negedge+1.
  task automatic cyc(input bit iv, input int ich, input logic [31:0] ib, input bit il,
                     input bit bv, input logic [1:0] br, input bit dr);
    bit   do_push, do_pop;
    ent_t h;
    do_push       = iv && (q.size() < MAX_OUT);
    issue_valid   = do_push;
    issue_channel = CH_WD'(ich);
    issue_bytes   = ib;
    issue_last    = il;
    m_axi_bvalid  = bv;
    m_axi_bresp   = br;
    done_ready    = dr;
    #1;
    if (done_valid && dr)
      obs.push_back('{ch: done_channel, bytes: done_bytes, err: done_error, resp: done_resp});
    do_pop = bv && (q.size() != 0) && (!m_dv || dr);
    @(posedge clk);
    if (m_dv && dr) m_dv = 1'b0;
    if (do_pop) begin
      h = q.pop_front();
      m_acc[h.ch] = m_acc[h.ch] + h.bytes;
      if (br[1]) begin
        m_err[h.ch] = 1'b1;
        if (br > m_worst[h.ch]) m_worst[h.ch] = br;
      end
      if (h.last) begin
        m_dv  = 1'b1;
        m_rec = '{ch: h.ch, bytes: m_acc[h.ch], err: m_err[h.ch], resp: m_worst[h.ch]};
        m_acc[h.ch] = '0; m_err[h.ch] = 1'b0; m_worst[h.ch] = 2'b00;
      end
    end
    if (do_push) q.push_back('{ch: ich, bytes: ib, last: il});
    @(negedge clk);
    #1;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (q.size() == 0 && !m_dv) begin
        ok = 1'b1;
        break;
      end
      cyc(0, 0, 0, 0, 1, 2'b00, 1);
    end
    chk("drain_within_budget", 64'(ok), 64'(1));
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    issue_valid = 0; issue_channel = '0; issue_bytes = '0; issue_last = 0;
    m_axi_bvalid = 0; m_axi_bresp = 2'b00; done_ready = 0;
    #3;
    chk("rst_done_valid", 64'(done_valid), 64'(0));
    chk("rst_count", 64'(outstanding_count), 64'(0));
    chk("rst_bready", 64'(m_axi_bready), 64'(0));
    chk("rst_done_bytes", 64'(done_bytes), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    #1;
    chk("rst_issue_ready", 64'(issue_ready), 64'(1));

    // Single channel
    obs.delete();
    cyc(1, 2, 64, 0, 0, 2'b00, 1);
    cyc(1, 2, 16, 1, 1, 2'b00, 1);
    cyc(0, 0, 0, 0, 1, 2'b00, 1);
    drain();
    cyc(0, 0, 0, 0, 0, 2'b00, 1);
    chk("single_count", 64'(obs.size()), 64'(1));
    chk("single_ch", 64'(obs_at(0).ch), 64'(2));
    chk("single_bytes", 64'(obs_at(0).bytes), 64'(80));
    chk("single_err", 64'(obs_at(0).err), 64'(0));
    chk("single_resp", 64'(obs_at(0).resp), 64'(0));
    chk("single_outstanding", 64'(outstanding_count), 64'(0));

    // Error merge, then a clean transfer on the same channel
    obs.delete();
    cyc(1, 1, 64, 0, 0, 2'b00, 1);
    cyc(1, 1, 64, 0, 1, 2'b00, 1);
    cyc(1, 1, 64, 1, 1, 2'b10, 1);
    cyc(0, 0, 0, 0, 1, 2'b00, 1);
    cyc(1, 1, 32, 1, 0, 2'b00, 1);
    cyc(0, 0, 0, 0, 1, 2'b00, 1);
    drain();
    chk("errmerge_bytes", 64'(obs_at(0).bytes), 64'(192));
    chk("errmerge_err", 64'(obs_at(0).err), 64'(1));
    chk("errmerge_resp", 64'(obs_at(0).resp), 64'(2));
    chk("errclear_bytes", 64'(obs_at(1).bytes), 64'(32));
    chk("errclear_err", 64'(obs_at(1).err), 64'(0));

    // Interleaved channels
    obs.delete();
    cyc(1, 0, 32, 0, 0, 2'b00, 1);
    cyc(1, 3, 16, 1, 1, 2'b00, 1);
    cyc(1, 0, 32, 1, 1, 2'b00, 1);
    cyc(0, 0, 0, 0, 1, 2'b00, 1);
    cyc(0, 0, 0, 0, 1, 2'b00, 1);
    drain();
    chk("ilv_first_ch", 64'(obs_at(0).ch), 64'(3));
    chk("ilv_first_bytes", 64'(obs_at(0).bytes), 64'(16));
    chk("ilv_second_ch", 64'(obs_at(1).ch), 64'(0));
    chk("ilv_second_bytes", 64'(obs_at(1).bytes), 64'(64));

    // Full FIFO and completion backpressure
    obs.delete();
    cyc(1, 5, 8, 0, 0, 2'b00, 1);
    cyc(1, 5, 8, 1, 0, 2'b00, 1);
    cyc(1, 6, 4, 1, 0, 2'b00, 1);
    cyc(1, 7, 4, 1, 0, 2'b00, 1);
    chk("full_issue_ready", 64'(issue_ready), 64'(0));
    chk("full_count", 64'(outstanding_count), 64'(4));
    cyc(0, 0, 0, 0, 1, 2'b00, 1);
    chk("full_pop_count", 64'(outstanding_count), 64'(3));
    cyc(1, 7, 4, 1, 1, 2'b00, 0);
    chk("simul_count", 64'(outstanding_count), 64'(3));
    chk("simul_done_bytes", 64'(done_bytes), 64'(16));
    cyc(1, 6, 4, 1, 1, 2'b00, 0);
    chk("hold_bready", 64'(m_axi_bready), 64'(0));
    chk("hold_count", 64'(outstanding_count), 64'(4));
    chk("hold_done_ch", 64'(done_channel), 64'(5));
    cyc(0, 0, 0, 0, 1, 2'b00, 0);
    chk("hold2_done_valid", 64'(done_valid), 64'(1));
    chk("hold2_done_bytes", 64'(done_bytes), 64'(16));
    drain();
    chk("full_first_rec_ch", 64'(obs_at(0).ch), 64'(5));
    chk("full_rec_total", 64'(obs.size()), 64'(5));

    // Back-to-back completions
    cyc(1, 4, 100, 1, 0, 2'b00, 1);
    cyc(1, 5, 200, 1, 1, 2'b00, 1);
    chk("b2b_first_valid", 64'(done_valid), 64'(1));
    chk("b2b_first_ch", 64'(done_channel), 64'(4));
    cyc(0, 0, 0, 0, 1, 2'b00, 1);
    chk("b2b_second_valid", 64'(done_valid), 64'(1));
    chk("b2b_second_ch", 64'(done_channel), 64'(5));
    chk("b2b_second_bytes", 64'(done_bytes), 64'(200));
    drain();

    // Reset mid-flight
    cyc(1, 6, 16, 0, 0, 2'b00, 1);
    cyc(1, 6, 32, 0, 1, 2'b00, 1);
    cyc(1, 6, 8, 0, 1, 2'b00, 1);
    cyc(1, 6, 4, 0, 0, 2'b00, 1);
    cyc(1, 6, 2, 1, 0, 2'b00, 1);
    chk("pre_rst_count", 64'(outstanding_count), 64'(3));
    issue_valid = 0; m_axi_bvalid = 1; done_ready = 1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_done_valid", 64'(done_valid), 64'(0));
    chk("midrst_count", 64'(outstanding_count), 64'(0));
    chk("midrst_bready", 64'(m_axi_bready), 64'(0));
    @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    obs.delete();
    cyc(1, 6, 8, 1, 0, 2'b00, 1);
    cyc(0, 0, 0, 0, 1, 2'b00, 1);
    drain();
    chk("postrst_count", 64'(obs.size()), 64'(1));
    chk("postrst_bytes", 64'(obs_at(0).bytes), 64'(8));

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] b;
      b = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(1, 256));
      cyc($urandom_range(0, 99) < 55, $urandom_range(0, CH_CNT - 1), b,
          $urandom_range(0, 2) == 0, $urandom_range(0, 99) < 60,
          2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
